uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter that drives the board-level uart_tx pin from the SoC side.
- Bytes enter through a valid/ready handshake into a small FIFO.
- A bit-timing FSM serialises them LSB first at BAUD_RATE, derived from CLK_FREQ.
- Complements the existing receive path so the SoC can stream console output without polling per bit.

---
 rtl/uart_tx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Bytes are accepted through a valid/ready handshake into a circular FIFO.
// A four-state bit-timing FSM pops them and shifts them out LSB first.
// Each bit lasts CLKS_PER_BIT clocks, and back-to-back frames have no idle gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ        = 27_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       busy,
    output logic                       uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DEPTH        = 2 ** FIFO_DEPTH_LOG2;

    localparam logic [CNT_W-1:0]         CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    // Reject configurations that cannot time a bit or hold a byte
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH_LOG2 < 1) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH_LOG2 must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                     state_q,   state_d;
    logic [CNT_W-1:0]           clk_cnt_q, clk_cnt_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [7:0]                 shift_q,   shift_d;
    logic                       tx_q,      tx_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q,  wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q,  rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q,   count_d;
    logic [7:0]                 mem_q [DEPTH];

    logic push;
    logic pop;
    logic fifo_empty;
    logic bit_done;

    // Storage array: written only on an accepted transfer, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // State register: control flops reset, the shift register is data only
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
        shift_q <= shift_d;
    end

    // Output / handshake decode from registered state
    always_comb begin
        fifo_empty = (count_q == '0);
        bit_done   = (clk_cnt_q == CNT_MAX);
        in_ready   = (count_q != CNT_FULL);
        push       = in_valid && in_ready;
        pop        = 1'b0;
        if (!fifo_empty) begin
            if (state_q == S_IDLE) begin
                pop = 1'b1;
            end else if (state_q == S_STOP && bit_done) begin
                pop = 1'b1;
            end
        end
        busy       = (state_q != S_IDLE) || !fifo_empty;
        fifo_count = count_q;
        uart_tx    = tx_q;
    end

    // Next-state logic for the bit-timing FSM and the FIFO pointers
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    clk_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Shift right so the next bit to send is always at index 1
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (pop) begin
                        // Chain straight into the next start bit, no idle gap
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo.
// The small instance runs at 4 clocks per bit with a 4-entry FIFO.
// The default-parameter instance times a full 234-clock-per-bit frame.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] fifo_count;
    logic       busy;
    logic       uart_tx;

    logic [7:0] d_in_data;
    logic       d_in_valid;
    logic       d_in_ready;
    logic [4:0] d_fifo_count;
    logic       d_busy;
    logic       d_uart_tx;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ        (400),
        .BAUD_RATE       (100),
        .FIFO_DEPTH_LOG2 (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .uart_tx    (uart_tx)
    );

    uart_tx_fifo u_def (
        .clk        (clk),
        .rst        (rst),
        .in_data    (d_in_data),
        .in_valid   (d_in_valid),
        .in_ready   (d_in_ready),
        .fifo_count (d_fifo_count),
        .busy       (d_busy),
        .uart_tx    (d_uart_tx)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // bit 0 = start bit, bit 9 = stop bit, in time order
    } vec_t;

    vec_t vecs [5];

    int checks = 0;
    int passes = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Checks 10 bits x CPB cycles starting with the current sample; busy must hold high throughout
    task automatic check_frame(input logic [9:0] line, input string name);
        logic [3:0] seen;
        int         busy_low;
        busy_low = 0;
        for (int b = 0; b < 10; b++) begin
            seen = '0;
            for (int c = 0; c < CPB; c++) begin
                seen[c] = uart_tx;
                if (busy !== 1'b1) busy_low++;
                tick();
            end
            chk($sformatf("%s bit%0d", name, b), int'(seen), line[b] ? 15 : 0);
        end
        chk($sformatf("%s busy held", name), busy_low, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b3 [6];
        logic [9:0] l3 [6];
        logic [9:0] p6;
        int         n;
        int         total;
        int         bad;
        logic       lvl;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        b3[0] = 8'h01; l3[0] = 10'b1000000010;
        b3[1] = 8'h02; l3[1] = 10'b1000000100;
        b3[2] = 8'h04; l3[2] = 10'b1000001000;
        b3[3] = 8'h80; l3[3] = 10'b1100000000;
        b3[4] = 8'h7E; l3[4] = 10'b1011111100;
        b3[5] = 8'hC3; l3[5] = 10'b1110000110;

        p6 = 10'b1010101010;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        d_in_valid = 1'b0;
        d_in_data  = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst uart_tx",    32'(uart_tx),    1);
        chk("rst fifo_count", 32'(fifo_count), 0);
        chk("rst in_ready",   32'(in_ready),   1);
        chk("rst busy",       32'(busy),       0);
        chk("rst def uart_tx", 32'(d_uart_tx), 1);
        chk("rst def busy",   32'(d_busy),     0);
        rst = 1'b0;
        tick();

        // Single frames from idle, table driven
        for (int i = 0; i < 5; i++) begin
            in_data  = vecs[i].data;
            in_valid = 1'b1;
            tick();                                   // edge N: accepted
            in_valid = 1'b0;
            in_data  = 8'hEE;
            chk($sformatf("v%0d count after accept", i), 32'(fifo_count), 1);
            chk($sformatf("v%0d busy after accept", i),  32'(busy),       1);
            chk($sformatf("v%0d line idle at N", i),     32'(uart_tx),    1);
            tick();                                   // edge N+1: popped
            chk($sformatf("v%0d count after pop", i),    32'(fifo_count), 0);
            check_frame(vecs[i].line, $sformatf("v%0d", i));
            chk($sformatf("v%0d busy after N+41", i),    32'(busy),       0);
            chk($sformatf("v%0d line idle after", i),    32'(uart_tx),    1);
            tick();
        end

        // Back-to-back 0x00 then 0xFF
        in_data  = 8'h00;
        in_valid = 1'b1;
        tick();
        chk("b2b count 1st", 32'(fifo_count), 1);
        in_data = 8'hFF;
        tick();
        chk("b2b count 2nd", 32'(fifo_count), 1);
        in_valid = 1'b0;
        check_frame(10'b1000000000, "b2b f0");
        chk("b2b count 3rd", 32'(fifo_count), 0);
        check_frame(10'b1111111110, "b2b f1");
        chk("b2b busy end", 32'(busy), 0);
        tick();

        // Fill to full with backpressure, six bytes in order
        fork
            begin
                int k;
                for (k = 0; k < 5; k++) begin
                    in_data  = b3[k];
                    in_valid = 1'b1;
                    tick();
                end
                chk("full count",    32'(fifo_count), 4);
                chk("full in_ready", 32'(in_ready),   0);
                in_data = b3[5];
                k = 0;
                while (!in_ready && k < 100) begin
                    tick();
                    k++;
                end
                chk("full ready reopen delay", k, 37);
                chk("full count at reopen", 32'(fifo_count), 3);
                tick();
                in_valid = 1'b0;
                in_data  = 8'hEE;
                chk("full count after byte5", 32'(fifo_count), 4);
            end
            begin
                tick();
                tick();
                for (int k = 0; k < 6; k++) begin
                    check_frame(l3[k], $sformatf("full f%0d", k));
                end
                chk("full busy end", 32'(busy), 0);
            end
        join
        tick();

        // Reset during DATA bit 3 with two bytes buffered
        in_valid = 1'b1;
        in_data  = 8'h81; tick();
        in_data  = 8'h3C; tick();
        in_data  = 8'hA5; tick();
        in_valid = 1'b0;
        chk("mid-rst count before", 32'(fifo_count), 2);
        repeat (16) tick();
        chk("mid-rst line in bit3", 32'(uart_tx), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-rst uart_tx",    32'(uart_tx),    1);
        chk("mid-rst fifo_count", 32'(fifo_count), 0);
        chk("mid-rst busy",       32'(busy),       0);
        chk("mid-rst in_ready",   32'(in_ready),   1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("mid-rst stays idle", bad, 0);

        // Write coinciding with a pop at the end of a stop bit
        fork
            begin
                in_data  = 8'h81; in_valid = 1'b1; tick();   // e0
                in_valid = 1'b0; tick();                     // e1
                in_data  = 8'h3C; in_valid = 1'b1; tick();   // e2
                in_valid = 1'b0;
                chk("pp count buffered", 32'(fifo_count), 1);
                repeat (38) tick();                          // after e40
                in_data  = 8'hC3; in_valid = 1'b1; tick();   // e41: push + pop
                in_valid = 1'b0;
                in_data  = 8'hEE;
                chk("pp count push+pop", 32'(fifo_count), 1);
            end
            begin
                tick();
                tick();
                check_frame(10'b1100000010, "pp f0");
                check_frame(10'b1001111000, "pp f1");
                check_frame(10'b1110000110, "pp f2");
                chk("pp busy end", 32'(busy), 0);
            end
        join
        tick();

        // Default parameters: 234 clocks per bit, 0x55
        d_in_data  = 8'h55;
        d_in_valid = 1'b1;
        tick();
        d_in_valid = 1'b0;
        chk("def count after accept", 32'(d_fifo_count), 1);
        tick();
        total = 0;
        for (int b = 0; b < 10; b++) begin
            lvl = d_uart_tx;
            chk($sformatf("def bit%0d level", b), 32'(lvl), 32'(p6[b]));
            n = 0;
            while (d_uart_tx === lvl && d_busy === 1'b1 && n < 300) begin
                tick();
                n++;
            end
            chk($sformatf("def bit%0d length", b), n, 234);
            total += n;
        end
        chk("def frame length", total, 2340);
        chk("def busy end", 32'(d_busy), 0);
        chk("def line idle", 32'(d_uart_tx), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
